// File: rtl/uart_imem_loader_pkg.sv
// Shared constants and state encodings for the UART instruction-memory loader.
// Optional checksum support is selected by UART_IMEM_LOADER_CHECKSUM_EN.
package uart_imem_loader_pkg;

  localparam int LOADER_LEN_BYTES = 2;
  localparam int UART_DATA_BITS   = 8;
  localparam int UART_STOP_BITS   = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
    S_ERR  = 3'd5,
    S_CHK  = 3'd6
`else
    S_ERR  = 3'd5
`endif
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port: the loader drives it, the memory consumes it.
interface uart_imem_loader_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata);
  modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/error pulses.
module uart_rx_byte
  import uart_imem_loader_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      uart_rx,
  output logic                      byte_valid,
  output logic [UART_DATA_BITS-1:0] byte_data,
  output logic                      frame_err
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W        = $clog2(UART_DATA_BITS);

  rx_state_e                 state_q, state_d;
  logic [1:0]                sync_q;
  logic                      rx_prev;
  logic [CNT_W-1:0]          cnt_q;
  logic [BIT_W-1:0]          bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      rx_s;
  logic                      bit_end;

  assign rx_s      = sync_q[1];
  assign bit_end   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_data = shift_q;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (rx_prev && !rx_s) state_d = RX_START;
      RX_START: if (cnt_q == CNT_W'(HALF_BIT - 1)) state_d = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_end && bit_idx_q == BIT_W'(UART_DATA_BITS - 1)) state_d = RX_STOP;
      RX_STOP:  if (bit_end && bit_idx_q == BIT_W'(UART_STOP_BITS - 1)) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RX_IDLE;
      sync_q     <= 2'b11;
      rx_prev    <= 1'b1;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[0], uart_rx};
      rx_prev    <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q     <= '0;
          bit_idx_q <= '0;
        end
        RX_START: cnt_q <= (cnt_q == CNT_W'(HALF_BIT - 1)) ? '0 : cnt_q + 1'b1;
        RX_DATA: begin
          if (bit_end) begin
            cnt_q     <= '0;
            shift_q   <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == BIT_W'(UART_STOP_BITS - 1)) begin
              byte_valid <= rx_s;
              frame_err  <= !rx_s;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

endmodule

// File: rtl/uart_imem_loader.sv
// Loads a length-prefixed little-endian word image from UART into instruction memory.
// Define UART_IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       uart_rx,
  uart_imem_loader_if.master         imem,
  output logic                       cpu_hold,
  output logic                       done,
  output logic                       err
);

  localparam int LEN_W = 8 * LOADER_LEN_BYTES;
  localparam logic [LEN_W:0] MAX_WORDS = (LEN_W + 1)'(1) << ADDR_WIDTH;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e S_TAIL = S_CHK;
`else
  localparam loader_state_e S_TAIL = S_DONE;
`endif

  logic            byte_valid, frame_err;
  logic [7:0]      byte_data;
  logic            start_q, start_edge;
  loader_state_e   state_q, state_d;
  logic [LEN_W-1:0] len_q, len_full, word_idx_q;
  logic [1:0]      byte_idx_q;
  logic [23:0]     asm_q;
  logic            last_byte;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  // start_q tracks even during reset so a button held through reset does not arm a load.
  always_ff @(posedge clk) start_q <= start;

  assign start_edge = start && !start_q;
  assign len_full   = {byte_data, len_q[7:0]};
  assign last_byte  = byte_valid && (byte_idx_q == 2'd3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (start_edge) state_d = S_LEN0;
      S_LEN0: begin
        if (frame_err)       state_d = S_ERR;
        else if (byte_valid) state_d = S_LEN1;
      end
      S_LEN1: begin
        if (frame_err) state_d = S_ERR;
        else if (byte_valid) begin
          if (len_full == '0)                       state_d = S_TAIL;
          else if ({1'b0, len_full} > MAX_WORDS)    state_d = S_ERR;
          else                                      state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (frame_err) state_d = S_ERR;
        else if (last_byte && (word_idx_q + 1'b1 == len_q)) state_d = S_TAIL;
      end
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (frame_err)       state_d = S_ERR;
        else if (byte_valid) state_d = (byte_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_hold = 1'b0;
    done     = (state_q == S_DONE);
    err      = (state_q == S_ERR);
    case (state_q)
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      S_LEN0, S_LEN1, S_DATA, S_CHK: cpu_hold = 1'b1;
`else
      S_LEN0, S_LEN1, S_DATA:        cpu_hold = 1'b1;
`endif
      default:                       cpu_hold = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      len_q           <= '0;
      word_idx_q      <= '0;
      byte_idx_q      <= '0;
      asm_q           <= '0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      csum_q          <= '0;
`endif
    end else begin
      state_q      <= state_d;
      imem.imem_we <= 1'b0;
      case (state_q)
        S_LEN0: if (byte_valid) len_q[7:0] <= byte_data;
        S_LEN1: begin
          if (byte_valid) begin
            len_q[15:8] <= byte_data;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
          end
        end
        S_DATA: begin
          if (byte_valid) begin
            byte_idx_q <= byte_idx_q + 1'b1;
            case (byte_idx_q)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              default: begin
                imem.imem_we    <= 1'b1;
                imem.imem_addr  <= word_idx_q[ADDR_WIDTH-1:0];
                imem.imem_wdata <= {byte_data, asm_q};
                word_idx_q      <= word_idx_q + 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
`ifdef UART_IMEM_LOADER_CHECKSUM_EN
      if (byte_valid) begin
        if (state_q == S_LEN0)                         csum_q <= byte_data;
        else if (state_q == S_LEN1 || state_q == S_DATA) csum_q <= csum_q ^ byte_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader at 10 clocks per UART bit, ADDR_WIDTH=4.
module tb_uart_imem_loader;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int ADDR_WIDTH = 4;
  localparam int CPB        = CLK_FREQ / BAUD;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic uart_rx = 1'b1;
  logic cpu_hold, done, err;
  logic bv_prev = 1'b0;
  int   total = 0;
  int   bad = 0;
  wr_t  sb[$];
  wr_t  exp_wr;

  uart_imem_loader_if #(.ADDR_WIDTH(ADDR_WIDTH)) imem ();

  uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .uart_rx  (uart_rx),
    .imem     (imem),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(negedge clk) uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic push_wr(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    sb.push_back(w);
  endtask

  task automatic send_basic_image();
    logic [7:0] img [10];
    img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h67, 8'h80, 8'h00, 8'h00};
    push_wr(0, 32'h00A00513);
    push_wr(1, 32'h00008067);
    for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
  endtask

  task automatic check_flags(input string tag, input logic h, input logic d, input logic e);
    check({tag, "_hold"}, cpu_hold, h);
    check({tag, "_done"}, done, d);
    check({tag, "_err"}, err, e);
  endtask

  // Write monitor: every strobe must match the next scoreboard entry and follow a byte_valid.
  always @(negedge clk) begin
    if (imem.imem_we) begin
      check("we_latency", bv_prev, 1'b1);
      if (sb.size() == 0) begin
        check("we_unexpected", imem.imem_we, 1'b0);
      end else begin
        exp_wr = sb.pop_front();
        check("we_addr", imem.imem_addr, exp_wr.addr);
        check("we_data", imem.imem_wdata, exp_wr.data);
      end
    end
    bv_prev = dut.u_rx.byte_valid;
  end

  initial begin
    // Reset with start held high.
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_we", imem.imem_we, 1'b0);
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // A byte in IDLE is discarded.
    send_byte(8'h03, 1'b1);
    check_flags("idle_byte", 1'b0, 1'b0, 1'b0);

    // Basic two-word load, with a start pulse during DATA that must be ignored.
    pulse_start();
    check_flags("arm", 1'b1, 1'b0, 1'b0);
    push_wr(0, 32'h00A00513);
    push_wr(1, 32'h00008067);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hA0, 1'b1);
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'h67, 1'b1);
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    check_flags("basic_mid", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1);
    check_flags("basic", 1'b0, 1'b1, 1'b0);
    check("basic_drain", sb.size(), 0);

    // Zero length, preceded by a line glitch that must not become a byte.
    pulse_start();
    check_flags("zero_arm", 1'b1, 1'b0, 1'b0);
    @(negedge clk) uart_rx = 1'b0;
    repeat (2) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_flags("zero", 1'b0, 1'b1, 1'b0);

    // Framing error on the third data byte, then recovery.
    pulse_start();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hA0, 1'b0);
    check_flags("frame", 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b1);
    check_flags("frame_stick", 1'b0, 1'b0, 1'b1);
    pulse_start();
    send_basic_image();
    check_flags("recover", 1'b0, 1'b1, 1'b0);
    check("recover_drain", sb.size(), 0);

    // Oversize: N=17 exceeds 16 words.
    pulse_start();
    send_byte(8'h11, 1'b1);
    send_byte(8'h00, 1'b1);
    check_flags("oversize", 1'b0, 1'b0, 1'b1);

    // Boundary: N=16 is accepted and waits for data.
    pulse_start();
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    check_flags("max_len", 1'b1, 1'b0, 1'b0);

    // Mid-load reset after five data bytes.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    pulse_start();
    push_wr(0, 32'h00A00513);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'hA0, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h67, 1'b1);
    check("midrst_drain", sb.size(), 0);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("midrst_we", imem.imem_we, 1'b0);
    check_flags("midrst", 1'b0, 1'b0, 1'b0);
    check("midrst_state", dut.state_q, 3'd0);
    rst_n = 1'b1;
    send_byte(8'h80, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check_flags("post_rst", 1'b0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    check("final_drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL timeout got=%0d want=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Writer side of the instruction-memory interface. The CPU's fetch stage only reads instruction memory; this block fills it.
- Receives a program image over a UART RX line, assembles little-endian 32-bit words and issues single-cycle word writes to the instruction-memory write port.
- Holds the CPU in reset while loading. Sits beside the CPU in the top level, driven by a board button (start) and the board UART pin.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer division.
- ADDR_WIDTH, 14, instruction-memory word-address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level or pulse; a rising edge arms a load.
- uart_rx  in  1  asynchronous serial input, idle high, 8N1.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_WIDTH  word address of write.
- imem_wdata  out  32  write data.
- cpu_hold  out  1  high while loading; top level ORs it into CPU reset.
- done  out  1  sticky; high after a successful load.
- err  out  1  sticky; high after a framing/length error.

Behaviour:
- Reset, sampled on the rising clk edge while rst_n=0: all outputs 0, FSM in IDLE, counters 0. rst_n low mid-load aborts immediately; no further imem_we.
- uart_rx passes through a 2-flop synchronizer before use.
- Start detection: start is registered; a rising edge is detected against the registered value.
- RX sub-block:
  - Falling edge on the synchronized line starts a frame.
  - Re-sample at CLKS_PER_BIT/2. If the line is high, treat it as a glitch and return to idle without a byte.
  - Sample 8 data bits LSB-first, one every CLKS_PER_BIT.
  - Sample the stop bit. If it is 1, emit byte_valid for one cycle with byte_data. If it is 0, emit frame_err for one cycle.
- Image format, in order:
  - LEN0, LEN1: word count N, 16-bit little-endian.
  - N×4 data bytes, each word little-endian (first byte goes to bits [7:0]).
- FSM states: IDLE, LEN0, LEN1, DATA, DONE, ERR.
- IDLE:
  - cpu_hold=0.
  - start edge → LEN0, with cpu_hold=1 and done/err cleared.
  - Bytes arriving in IDLE are discarded.
- LEN0: byte_valid → latch N[7:0], go to LEN1.
- LEN1: byte_valid → latch N[15:8], then:
  - N=0 → DONE.
  - N > 2^ADDR_WIDTH → ERR.
  - Otherwise → DATA with word_idx=0 and byte_idx=0.
- DATA:
  - Each byte_valid shifts into the assembly register at lane byte_idx; byte_idx then increments mod 4.
  - On the byte with byte_idx=3: the next cycle drives imem_we=1, imem_addr=word_idx and imem_wdata=the assembled word, registered. word_idx then increments.
  - If word_idx+1 == N, go to DONE in the same cycle as the strobe.
  - Latency is exactly 1 clk from the fourth byte_valid to imem_we.
- DONE: cpu_hold=0, done=1.
- ERR: cpu_hold=0, err=1. Memory contents are undefined after an error.
- frame_err in LEN0/LEN1/DATA → ERR. In IDLE/DONE/ERR it is ignored.
- start edge in DONE/ERR → LEN0, which restarts the load.
- start edge in LEN0/LEN1/DATA is ignored.
- Simultaneous byte_valid and start edge in IDLE: the start edge wins and the byte is discarded.
- No timeout: a partial image leaves the block in DATA with cpu_hold=1 until reset or completion.

Optional Feature:
- Macro: UART_IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - An extra state CHK follows the last data byte; the N=0 path also goes to CHK.
  - Block accumulates the XOR of all bytes from LEN0 through the final data byte.
  - Expects one trailing checksum byte. Match → DONE; mismatch → ERR.
  - imem_we strobes are unaffected.
- Undefined: no CHK state, no accumulator, no trailing byte expected.

Decomposition:
- Shared package/header: FSM state encodings (3-bit), LOADER_LEN_BYTES=2, and the UART frame constants (data bits 8, stop bits 1).
- One sub-module, uart_rx_byte, containing the synchronizer, baud counter and bit FSM. Outputs: byte_valid, byte_data[7:0], frame_err.

Test Plan:
All scenarios run with CLK_FREQ=1_000_000 and BAUD=100_000, giving 10 clks/bit.
- Reset: hold rst_n=0 for 3 clks with start=1 → all outputs 0, no imem_we.
- Basic load: start edge, then bytes 02 00 13 05 A0 00 67 80 00 00:
  - imem_we at addr 0 with 0x00A00513, one clk after the 6th byte_valid.
  - imem_we at addr 1 with 0x00008067.
  - Then done=1, cpu_hold=0.
- Zero length: send 00 00 → done=1, no imem_we.
- Framing error: send the 3rd data byte with stop bit 0 → err=1, no strobe for that word, cpu_hold=0. A following start edge plus a valid image → done=1, err=0.
- Oversize with ADDR_WIDTH=4: send 11 00 (N=17 > 16) → err=1.
- Mid-load reset: pull rst_n low after 5 data bytes → outputs 0 and FSM IDLE. Remaining bytes produce no imem_we.
